d_debounce_sync: RTL and testbench
==================================

// Module: d_debounce_sync
// PURPOSE
//  Input-conditioning stage that sits directly upstream of the d_ff block and drives its d input.
//  Synchronises a raw asynchronous input (switch/pin) into the clk domain.
//  Debounces it with a per-direction stability counter.
//  Outputs a clean registered level plus one-cycle rise/fall pulses.
// PARAMETERS
//  SYNC_STAGES      2   number of synchroniser flops (>=2)
//  DEBOUNCE_CYCLES  4   consecutive stable samples needed to accept a new level (>=2)
//  CNT_W            4   stability counter width; DEBOUNCE_CYCLES <= 2**CNT_W
// PORTS
//  clk     input   1  sole clock, rising-edge
//  reset   input   1  asynchronous, active-high; clears all state
//  din     input   1  raw asynchronous input
//  enable  input   1  1 = FSM/counter advance; 0 = freeze
//  d       output  1  debounced level (feeds d_ff.d)
//  d_rise  output  1  one-cycle pulse on accepted 0->1 of d
//  d_fall  output  1  one-cycle pulse on accepted 1->0 of d
//  busy    output  1  high while a candidate transition is being counted
// BEHAVIOUR
//  Reset (async, immediate, no clk needed):
//   - sync chain = 0, state = STABLE_LO, cnt = 0
//   - d = 0, d_rise = 0, d_fall = 0, busy = 0
//  Sync chain: din shifts through SYNC_STAGES flops every edge (enable has no effect); last flop = s.
//  FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO. Evaluated only when enable=1.
//   - STABLE_LO: s=1 -> WAIT_HI, cnt<=1; else hold.
//   - WAIT_HI:   s=0 -> STABLE_LO, cnt<=0 (glitch rejected, no pulse).
//                s=1 & cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, d<=1, d_rise<=1, cnt<=0.
//                s=1 otherwise -> cnt<=cnt+1.
//   - STABLE_HI / WAIT_LO: mirror image (s=0 counts; d<=0 and d_fall<=1 on acceptance).
//  Latency: number the edge that first captures new din as edge 1.
//   - d changes on edge SYNC_STAGES+DEBOUNCE_CYCLES (defaults: edge 6).
//  d_rise / d_fall:
//   - registered; high exactly one cycle, on the same edge d changes
//   - never both high; 0 on any cycle without an acceptance
//  busy: registered, =1 iff state is WAIT_HI or WAIT_LO.
//  enable=0: state, cnt and d hold; d_rise/d_fall forced 0 that cycle; sync chain still runs.
//  Counter: never wraps; cleared on every exit from a WAIT state.
//  Reset mid-operation: aborts any count/pulse; the next transition needs full latency again.
//  din toggling every cycle: FSM never leaves STABLE_x/WAIT_x pair; d is never updated.
// STRUCTURE
//  - Shared package debounce_pkg: 2-bit state encodings (STABLE_LO=0, WAIT_HI=1,
//    STABLE_HI=2, WAIT_LO=3) and default parameter constants.
//  - One sub-module: sync_chain (parameterised SYNC_STAGES-flop shift register,
//    async active-high reset to 0), instantiated once.
//  - Top level holds the FSM, cnt and output registers.
// TESTING (defaults SYNC_STAGES=2, DEBOUNCE_CYCLES=4, 10-unit clk period)
//  1. reset asserted between edges while d=1 -> d, d_rise, d_fall, busy = 0 with no clk edge.
//  2. din 0->1 held -> busy=1 after edges 3..5; d=1 and d_rise=1 after edge 6; d_rise=0 after edge 7.
//  3. din high 2 cycles then low -> d stays 0, no d_rise, busy returns 0.
//  4. from d=1, din 1->0 held -> d=0 and d_fall=1 at edge 6, for one cycle only.
//  5. din held 1, enable=0 for 3 cycles during WAIT_HI -> d rises at edge 9; no pulse while enable=0.
//  6. reset pulse during WAIT_HI (cnt=2), din kept 1 -> d=0, busy=0;
//     after release, d rises 6 edges later.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and default constants for the debounce/synchroniser input stage.
package debounce_pkg;

    typedef enum logic [1:0] {
        StableLo = 2'd0,
        WaitHi   = 2'd1,
        StableHi = 2'd2,
        WaitLo   = 2'd3
    } state_e;

    localparam int unsigned SyncStagesDef     = 2;
    localparam int unsigned DebounceCyclesDef = 4;
    localparam int unsigned CntWDef           = 4;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser: shifts an asynchronous input into the clk domain.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic s
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Next value: shift din into the bottom of the chain.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
    end

    // Chain flops, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign s = sync_q[STAGES-1];

endmodule

// File: rtl/d_debounce_sync.sv
// Input conditioner: synchronises din, debounces it per direction and produces a clean
// registered level with one-cycle rise/fall pulses.
module d_debounce_sync
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SyncStagesDef,
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDef,
    parameter int unsigned CNT_W           = CntWDef
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic enable,
    output logic d,
    output logic d_rise,
    output logic d_fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             d_q, d_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;

    sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync_chain (
        .clk  (clk),
        .reset(reset),
        .din  (din),
        .s    (s)
    );

    // Next-state logic: a candidate level must be seen DEBOUNCE_CYCLES times in a row.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (enable) begin
            unique case (state_q)
                StableLo: begin
                    if (s) begin
                        state_d = WaitHi;
                        cnt_d   = CNT_W'(1);
                    end
                end
                WaitHi: begin
                    if (!s) begin
                        state_d = StableLo;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d = StableHi;
                        d_d     = 1'b1;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StableHi: begin
                    if (!s) begin
                        state_d = WaitLo;
                        cnt_d   = CNT_W'(1);
                    end
                end
                WaitLo: begin
                    if (s) begin
                        state_d = StableHi;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d = StableLo;
                        d_d     = 1'b0;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
        busy_d = (state_d == WaitHi) || (state_d == WaitLo);
    end

    // FSM, counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StableLo;
            cnt_q   <= '0;
            d_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign d      = d_q;
    assign d_rise = rise_q;
    assign d_fall = fall_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_d_debounce_sync.sv
// Self-checking bench for d_debounce_sync: vector table, directed corner cases and
// randomized stimulus against a run-length reference model.
module tb_d_debounce_sync;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 4;

    logic clk, reset, din, enable;
    logic d, d_rise, d_fall, busy;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: ideal delay line plus a count of consecutive enabled samples
    // that disagree with the accepted level.
    logic m_pipe [SYNC];
    logic m_d, m_rise, m_fall, m_busy;
    int   m_run;

    typedef struct {
        logic din;
        logic en;
        logic d;
        logic rise;
        logic fall;
        logic busy;
    } vec_t;

    vec_t tbl[21];

    d_debounce_sync #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .enable(enable),
        .d     (d),
        .d_rise(d_rise),
        .d_fall(d_fall),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic check_all(input string name, input logic ed, input logic er,
                             input logic ef, input logic eb);
        check({name, ".d"}, d, ed);
        check({name, ".d_rise"}, d_rise, er);
        check({name, ".d_fall"}, d_fall, ef);
        check({name, ".busy"}, busy, eb);
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(SYNC); i++) m_pipe[i] = 1'b0;
        m_d = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0; m_run = 0;
    endtask

    task automatic model_edge(input logic din_v, input logic en_v);
        logic s_old;
        s_old = m_pipe[SYNC-1];
        for (int i = int'(SYNC) - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = din_v;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (en_v) begin
            if (s_old != m_d) begin
                m_run++;
                if (m_run == int'(DEB)) begin
                    m_d    = s_old;
                    m_rise = s_old;
                    m_fall = !s_old;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        m_busy = (m_run != 0);
    endtask

    // One clock: drive inputs, advance the model at the edge, settle 1 unit after.
    task automatic step(input logic din_v, input logic en_v);
        din    = din_v;
        enable = en_v;
        @(posedge clk);
        model_edge(din_v, en_v);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic mid_reset(input string name);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all(name, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic cur;
        int   hold;
        reset  = 1'b1;
        din    = 1'b0;
        enable = 1'b1;
        model_reset();
        #1;
        check_all("por", 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;

        // Rise (7), fall (7), short glitch rejected (7).
        tbl[0]  = '{1, 1, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 0, 0, 0, 1};
        tbl[3]  = '{1, 1, 0, 0, 0, 1};
        tbl[4]  = '{1, 1, 0, 0, 0, 1};
        tbl[5]  = '{1, 1, 1, 1, 0, 0};
        tbl[6]  = '{1, 1, 1, 0, 0, 0};
        tbl[7]  = '{0, 1, 1, 0, 0, 0};
        tbl[8]  = '{0, 1, 1, 0, 0, 0};
        tbl[9]  = '{0, 1, 1, 0, 0, 1};
        tbl[10] = '{0, 1, 1, 0, 0, 1};
        tbl[11] = '{0, 1, 1, 0, 0, 1};
        tbl[12] = '{0, 1, 0, 0, 1, 0};
        tbl[13] = '{0, 1, 0, 0, 0, 0};
        tbl[14] = '{1, 1, 0, 0, 0, 0};
        tbl[15] = '{1, 1, 0, 0, 0, 0};
        tbl[16] = '{0, 1, 0, 0, 0, 1};
        tbl[17] = '{0, 1, 0, 0, 0, 1};
        tbl[18] = '{0, 1, 0, 0, 0, 0};
        tbl[19] = '{0, 1, 0, 0, 0, 0};
        tbl[20] = '{0, 1, 0, 0, 0, 0};
        for (int i = 0; i < 21; i++) begin
            step(tbl[i].din, tbl[i].en);
            check_all($sformatf("vec%0d", i), tbl[i].d, tbl[i].rise, tbl[i].fall, tbl[i].busy);
        end

        // Enable low for 3 cycles during WAIT_HI stretches acceptance to edge 9.
        for (int e = 1; e <= 9; e++) begin
            step(1'b1, !(e >= 4 && e <= 6));
            check_all($sformatf("freeze_e%0d", e), (e == 9), (e == 9), 1'b0,
                      (e >= 3 && e <= 8));
        end

        // Asynchronous reset while d=1, no clock edge needed.
        step(1'b1, 1'b1);
        check("pre_reset.d", d, 1'b1);
        mid_reset("async_rst");

        // Reset while counting (cnt=2): full latency needed again afterwards.
        for (int e = 1; e <= 4; e++) step(1'b1, 1'b1);
        check("wait_cnt2.busy", busy, 1'b1);
        mid_reset("abort_rst");
        for (int e = 1; e <= 6; e++) begin
            step(1'b1, 1'b1);
            check_all($sformatf("relat_e%0d", e), (e == 6), (e == 6), 1'b0,
                      (e >= 3 && e <= 5));
        end

        // Toggling every cycle never gets accepted.
        for (int e = 0; e < 20; e++) begin
            step(e[0], 1'b1);
            check($sformatf("toggle%0d.d", e), d, 1'b1);
            check($sformatf("toggle%0d.rise_fall", e), d_rise | d_fall, 1'b0);
        end

        // Randomized runs against the model.
        cur  = 1'b0;
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                cur  = $urandom_range(0, 1) == 1;
                hold = $urandom_range(1, 9);
            end
            hold--;
            if ($urandom_range(0, 299) == 0) mid_reset($sformatf("rnd_rst%0d", c));
            step(cur, $urandom_range(0, 7) != 0);
            check_all($sformatf("rnd%0d", c), m_d, m_rise, m_fall, m_busy);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
